// File: rtl/word_packer_128_if.sv
// Word-stream input and FIFO push side of the 128-bit word packer.
// The packer uses the slave modport; the word source/FIFO model uses master.
interface word_packer_128_if #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 4
);
    localparam int OUT_W = WORD_W * NUM_WORDS;

    logic [WORD_W-1:0] i_Word;
    logic              i_Word_Valid;
    logic              o_Word_Ready;
    logic              i_Buffer_Full;
    logic [OUT_W-1:0]  o_Data;
    logic              o_Data_Coming;

    modport master (
        output i_Word,
        output i_Word_Valid,
        input  o_Word_Ready,
        output i_Buffer_Full,
        input  o_Data,
        input  o_Data_Coming
    );

    modport slave (
        input  i_Word,
        input  i_Word_Valid,
        output o_Word_Ready,
        input  i_Buffer_Full,
        output o_Data,
        output o_Data_Coming
    );
endinterface

// File: rtl/word_packer_128.sv
// Packs NUM_WORDS narrow words (first word in the MSB lane) into one block for the FIFO.
// Optional PACKER_FLUSH_EN adds i_Flush to close a partial block zero-filled.
module word_packer_128 #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 4,
    parameter int CNT_W     = 16
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic             i_EN,
`ifdef PACKER_FLUSH_EN
    input  logic             i_Flush,
`endif
    word_packer_128_if.slave bus,
    output logic             o_Busy,
    output logic [CNT_W-1:0] o_Block_Count
);
    localparam int OUT_W = WORD_W * NUM_WORDS;
    localparam int CW    = $clog2(NUM_WORDS + 1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t           state_q, state_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic [OUT_W-1:0] data_q, data_n;
    logic [CNT_W-1:0] blk_q, blk_n;
    logic             ready;
    logic             xfer;
    logic             push;
    logic             flush;

`ifdef PACKER_FLUSH_EN
    assign flush = i_Flush;
`else
    assign flush = 1'b0;
`endif

    assign ready = i_EN & ~i_Reset & (state_q == FILL);
    assign xfer  = ready & bus.i_Word_Valid;
    assign push  = i_EN & ~i_Reset & ~bus.i_Buffer_Full
                 & (state_q == HOLD);

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        data_n  = data_q;
        blk_n   = blk_q;
        if (i_EN) begin
            unique case (state_q)
                FILL: begin
                    if (xfer) begin
                        for (int i = 0; i < NUM_WORDS; i++) begin
                            if (cnt_q == CW'(i))
                                data_n[OUT_W-1-i*WORD_W -: WORD_W] = bus.i_Word;
                        end
                        if (cnt_q == CW'(NUM_WORDS - 1)) begin
                            cnt_n   = '0;
                            state_n = HOLD;
                        end else begin
                            cnt_n = cnt_q + CW'(1);
                        end
                    end
                    // Partial close: lanes past the last written word are cleared
                    if (flush && (xfer || cnt_q != '0) && state_n == FILL) begin
                        for (int i = 0; i < NUM_WORDS; i++) begin
                            if (CW'(i) >= cnt_q + CW'(xfer))
                                data_n[OUT_W-1-i*WORD_W -: WORD_W] = '0;
                        end
                        cnt_n   = '0;
                        state_n = HOLD;
                    end
                end
                HOLD: begin
                    if (push) begin
                        state_n = FILL;
                        blk_n   = blk_q + CNT_W'(1);
                    end
                end
                default: state_n = FILL;
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q <= FILL;
            cnt_q   <= '0;
            data_q  <= '0;
            blk_q   <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            data_q  <= data_n;
            blk_q   <= blk_n;
        end
    end

    assign bus.o_Word_Ready  = ready;
    assign bus.o_Data        = data_q;
    assign bus.o_Data_Coming = push;
    assign o_Busy            = (cnt_q != '0) | (state_q == HOLD);
    assign o_Block_Count     = blk_q;
endmodule
